// File: rtl/cnt_sched_pkg.sv
// Shared state encoding and sizing helpers for the shared-counter scheduler.
// Combinational helpers only; no latency, no flow control.
package cnt_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  // Width of a counter able to hold 0..timeout; a disabled timeout still gets one bit.
  function automatic int to_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first request at or above a one-hot priority pointer, wrapping.
// Purely combinational; zero latency, no backpressure.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic         any_req
);

  logic [N-1:0] upper;
  logic [N-1:0] pick_src;

  // ptr is one-hot, so ptr-1 masks everything below the priority position.
  always_comb begin
    upper    = req & ~(ptr - N'(1));
    pick_src = (|upper) ? upper : req;
    gnt      = pick_src & (~pick_src + N'(1));
    any_req  = |req;
  end

endmodule

// File: rtl/cnt_share_sched.sv
// Round-robin sharing of one load/count counter: load start value, count to TC, report done/err.
// Grant registered one cycle after arbitration; min 4-cycle turnaround; requesters wait on level req.
module cnt_share_sched
  import cnt_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     CP,
  input  logic                     SR,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   load_val,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         err,
  output logic                     busy,
  output logic [WIDTH-1:0]         CNT_P,
  output logic                     CNT_PE,
  output logic                     CNT_CEP,
  output logic                     CNT_CET,
  input  logic                     CNT_TC
);

  localparam int              TO_W    = to_width(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state;
  logic [N_REQ-1:0]  ptr;
  logic [N_REQ-1:0]  ptr_next;
  logic [N_REQ-1:0]  arb_gnt;
  logic              arb_any;
  logic [WIDTH-1:0]  sel_val;
  logic [TO_W-1:0]   to_cnt;
  logic              timed_out;
  logic              withdrawn;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .any_req (arb_any)
  );

  // One-hot mux of the winner's start value, built bit-by-bit as an AND-OR tree.
  logic [WIDTH*N_REQ-1:0] masked_t;
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    for (genvar i = 0; i < N_REQ; i++) begin : g_req
      assign masked_t[b*N_REQ+i] = load_val[i*WIDTH+b] & arb_gnt[i];
    end
    assign sel_val[b] = |masked_t[b*N_REQ +: N_REQ];
  end

  // Rotating the held grant left by one gives the next one-hot priority position.
  assign ptr_next  = (gnt << 1) | (gnt >> (N_REQ - 1));
  assign withdrawn = ~|(req & gnt);
  assign timed_out = (TIMEOUT != 0) && (to_cnt == TO_LAST);

  always_ff @(posedge CP or negedge SR) begin
    if (!SR) begin
      state   <= IDLE;
      ptr     <= N_REQ'(1);
      gnt     <= '0;
      done    <= '0;
      err     <= '0;
      busy    <= 1'b0;
      CNT_P   <= '0;
      CNT_PE  <= 1'b1;
      CNT_CEP <= 1'b0;
      CNT_CET <= 1'b0;
      to_cnt  <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            state  <= LOAD;
            gnt    <= arb_gnt;
            CNT_P  <= sel_val;
            CNT_PE <= 1'b0;
            busy   <= 1'b1;
          end
        end
        LOAD: begin
          state   <= RUN;
          CNT_PE  <= 1'b1;
          CNT_CEP <= 1'b1;
          CNT_CET <= 1'b1;
          to_cnt  <= '0;
        end
        RUN: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (withdrawn) begin
            state   <= IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            CNT_CEP <= 1'b0;
            CNT_CET <= 1'b0;
            ptr     <= ptr_next;
          end else if (CNT_TC) begin
            state   <= DONE;
            done    <= gnt;
            CNT_CEP <= 1'b0;
            CNT_CET <= 1'b0;
          end else if (timed_out) begin
            state   <= ABORT;
            err     <= gnt;
            CNT_CEP <= 1'b0;
            CNT_CET <= 1'b0;
          end
        end
        DONE, ABORT: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
          ptr   <= ptr_next;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_share_sched.sv
// Bench for cnt_share_sched: directed scenarios then randomized grants against a transaction-level model.
module tb_cnt_share_sched;

  localparam int N   = 4;
  localparam int W   = 4;
  localparam int TO  = 8;

  localparam int K_TC  = 0;
  localparam int K_TO  = 1;
  localparam int K_WD  = 2;
  localparam int K_COL = 3;

  logic           CP;
  logic           SR;
  logic [N-1:0]   req;
  logic [N*W-1:0] load_val;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [N-1:0]   err;
  logic           busy;
  logic [W-1:0]   CNT_P;
  logic           CNT_PE;
  logic           CNT_CEP;
  logic           CNT_CET;
  logic           CNT_TC;

  int errors = 0;
  int checks = 0;
  int ptr_m  = 0;
  int g_seen;

  cnt_share_sched #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .CP       (CP),
    .SR       (SR),
    .req      (req),
    .load_val (load_val),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .CNT_P    (CNT_P),
    .CNT_PE   (CNT_PE),
    .CNT_CEP  (CNT_CEP),
    .CNT_CET  (CNT_CET),
    .CNT_TC   (CNT_TC)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"},  32'(gnt),  32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"},  32'(err),  32'd0);
  endtask

  // Entered at a falling edge with the DUT idle and req already driven; returns at a
  // falling edge with the DUT idle again. kind selects how the grant ends.
  task automatic one_grant(input int kind, input int j, input bit stale_tc, output int g);
    int  out_kind;
    logic [W-1:0] exp_val;
    g = rr_pick(req, ptr_m);
    if (g < 0) begin
      chk("no_request", 32'(req), 32'hF);
      return;
    end
    exp_val = load_val[g*W +: W];
    @(negedge CP);
    chk("load_gnt",  32'(gnt),               32'(1 << g));
    chk("load_pe",   32'(CNT_PE),            32'd0);
    chk("load_p",    32'(CNT_P),             32'(exp_val));
    chk("load_en",   32'({CNT_CEP, CNT_CET}), 32'd0);
    chk("load_busy", 32'(busy),              32'd1);
    load_val = 16'($urandom);
    CNT_TC   = stale_tc;
    out_kind = K_TO;
    for (int c = 0; c < TO; c++) begin
      @(negedge CP);
      chk("run_gnt", 32'(gnt), 32'(1 << g));
      chk("run_ctl", 32'({CNT_PE, CNT_CEP, CNT_CET}), 32'b111);
      chk("run_pulse", 32'({done, err}), 32'd0);
      CNT_TC = 1'b0;
      if (kind == K_WD && c == j) begin
        req[g] = 1'b0;
        out_kind = K_WD;
        break;
      end
      if ((kind == K_TC && c == j) || (kind == K_COL && c == TO - 1)) begin
        CNT_TC = 1'b1;
        out_kind = K_TC;
        break;
      end
    end
    @(negedge CP);
    CNT_TC = 1'b0;
    if (out_kind == K_WD) begin
      chk_idle("wd");
    end else begin
      chk("end_gnt",  32'(gnt),  32'(1 << g));
      chk("end_done", 32'(done), (out_kind == K_TC) ? 32'(1 << g) : 32'd0);
      chk("end_err",  32'(err),  (out_kind == K_TO) ? 32'(1 << g) : 32'd0);
      chk("end_ctl",  32'({CNT_PE, CNT_CEP, CNT_CET}), 32'b100);
      req[g] = 1'b0;
      @(negedge CP);
      chk_idle("post");
    end
    ptr_m = (g + 1) % N;
  endtask

  initial begin
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    SR = 1'b0; req = '0; load_val = '0; CNT_TC = 1'b0;

    #12;
    chk_idle("rst");
    chk("rst_ctl", 32'({CNT_PE, CNT_CEP, CNT_CET}), 32'b100);
    chk("rst_p",   32'(CNT_P), 32'd0);
    @(negedge CP);
    SR = 1'b1;
    @(negedge CP);
    chk_idle("idle0");

    // Single requester 1 with start value C, TC in the third RUN cycle.
    req = 4'b0010;
    load_val = 16'h00C0;
    one_grant(K_TC, 2, 1'b0, g_seen);
    chk("single_g", 32'(g_seen), 32'd1);

    // Reset asserted mid-RUN.
    req = 4'b0100;
    @(negedge CP);
    @(negedge CP);
    #2 SR = 1'b0;
    #1;
    chk_idle("midrst");
    chk("midrst_ctl", 32'({CNT_PE, CNT_CEP, CNT_CET}), 32'b100);
    chk("midrst_p",   32'(CNT_P), 32'd0);
    req = 4'b1111;
    @(negedge CP);
    SR = 1'b1;
    ptr_m = 0;

    // Round-robin with every requester active, TC after 2 RUN cycles.
    for (int k = 0; k < 5; k++) begin
      req = 4'b1111;
      load_val = 16'($urandom);
      one_grant(K_TC, 1, 1'b0, g_seen);
      chk("rr_order", 32'(g_seen), 32'(rr_exp[k]));
    end

    // Withdrawal of requester 0 in its third RUN cycle; pointer must then favour 1.
    req = 4'b0001;
    one_grant(K_WD, 2, 1'b0, g_seen);
    req = 4'b1111;
    one_grant(K_TC, 0, 1'b0, g_seen);
    chk("wd_next", 32'(g_seen), 32'd1);

    // Timeout with stale TC during LOAD, then TC coinciding with the timeout.
    req = 4'b0100;
    one_grant(K_TO, 0, 1'b1, g_seen);
    chk("to_g", 32'(g_seen), 32'd2);
    req = 4'b0100;
    one_grant(K_COL, 0, 1'b0, g_seen);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && ($urandom % 2 == 0)) req[i] = 1'b1;
      if (req == '0) req[$urandom % N] = 1'b1;
      load_val = 16'($urandom);
      one_grant($urandom % 4, $urandom_range(0, TO - 2), 1'($urandom % 2), g_seen);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
